// File: rtl/out_port_fifo.sv
// ----------------------------------------------------------------------------
// out_port_fifo
//
// Output-port buffer after the write-back stage. Each retiring OUT
// instruction's value goes into a first-word-fall-through FIFO. The FIFO
// drains to the display/serial consumer over a valid/ready handshake. The
// most recently accepted value is held for the 7-segment display. stall asks
// the CPU to withhold its clock enable while the buffer is full.
//
// Optional feature macro: OUT_TIMESTAMP_EN
//   When defined, a 16-bit free-running cycle counter is sampled into each
//   entry at push time. The sample is presented on rd_ts alongside rd_data.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-high
//   wr_valid   WB stage retires an OUT instruction this cycle
//   wr_data    value to output
//   full       occupancy == DEPTH
//   stall      hold request for CPU ce (equals full)
//   rd_valid   FIFO non-empty, rd_data valid
//   rd_ready   consumer accepts rd_data this cycle
//   rd_data    head entry (0 while empty)
//   last_data  last accepted wr_data
//   count      occupancy 0..DEPTH
//   overflow   sticky flag: a write was dropped
//   clr_ovf    clears overflow (a concurrent drop wins)
//   rd_ts      head entry timestamp (OUT_TIMESTAMP_EN only, 0 while empty)
// ----------------------------------------------------------------------------
module out_port_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              full,
    output logic              stall,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] last_data,
    output logic [AW:0]       count,
    output logic              overflow,
`ifdef OUT_TIMESTAMP_EN
    output logic [15:0]       rd_ts,
`endif
    input  logic              clr_ovf
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              push;
    logic              pop;
    logic              drop;

    // Status flags come from registered count only, so there is no
    // combinational path from rd_ready to rd_valid or stall.
    assign full     = (count == FULL_CNT);
    assign stall    = full;
    assign rd_valid = (count != '0);

    assign pop  = rd_valid & rd_ready;
    // A full FIFO still accepts a write when the head leaves the same cycle.
    assign push = wr_valid & (~full | pop);
    assign drop = wr_valid & full & ~pop;

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

    // Storage array is not reset; stale contents are masked by rd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            last_data <= '0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_data <= wr_data;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef OUT_TIMESTAMP_EN
    logic [15:0] ts_cnt;
    logic [15:0] ts_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ts_mem[wr_ptr] <= ts_cnt;
        end
    end

    assign rd_ts = rd_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule
